shared_ram_arbiter: RTL and testbench

Shares one single-port RAM between `REQUESTERS` independent clients, one access per cycle. Arbitration is round-robin by default, with per-requester valid/ready request handshakes and a fixed-latency read-response return path. Sits directly in front of `single_port_ram`, driving its enables, address and write data, and consuming its registered read data.

---
 rtl/shared_ram_arbiter.sv | 109 ++++++++++
 tb/tb_shared_ram_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among REQUESTERS clients.
// Define SHARED_RAM_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module shared_ram_arbiter #(
  parameter int REQUESTERS    = 2,
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [REQUESTERS-1:0]               request_valid,
  output logic [REQUESTERS-1:0]               request_ready,
  input  logic [REQUESTERS-1:0]               request_write,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] request_address,
  input  logic [REQUESTERS*WIDTH-1:0]         request_write_data,
  output logic [REQUESTERS-1:0]               response_valid,
  output logic [WIDTH-1:0]                    response_data,
  output logic                                memory_write_enable,
  output logic                                memory_read_enable,
  output logic [ADDRESS_WIDTH-1:0]            memory_address,
  output logic [WIDTH-1:0]                    memory_write_data,
  input  logic [WIDTH-1:0]                    memory_read_data
);

  localparam int POINTER_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [POINTER_WIDTH-1:0] priority_pointer_s;
  logic [POINTER_WIDTH-1:0] next_pointer_s;
  logic [REQUESTERS-1:0]    grant_s;
  logic                     found_s;
  logic [REQUESTERS-1:0]    response_valid_r;

  // Grant search: first valid index at or after the pointer, then wrap to the indices below it.
  always_comb begin
    grant_s        = '0;
    found_s        = 1'b0;
    next_pointer_s = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (!found_s && !reset && (k >= int'(priority_pointer_s)) && request_valid[k]) begin
        found_s        = 1'b1;
        grant_s[k]     = 1'b1;
        next_pointer_s = (k == REQUESTERS - 1) ? '0 : POINTER_WIDTH'(k + 1);
      end else begin
        found_s = found_s;
      end
    end
    for (int k = 0; k < REQUESTERS; k++) begin
      if (!found_s && !reset && (k < int'(priority_pointer_s)) && request_valid[k]) begin
        found_s        = 1'b1;
        grant_s[k]     = 1'b1;
        next_pointer_s = (k == REQUESTERS - 1) ? '0 : POINTER_WIDTH'(k + 1);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign request_ready = grant_s;

  // RAM drive muxed from the granted client; all-zero when nobody is granted.
  always_comb begin
    memory_write_enable = 1'b0;
    memory_read_enable  = 1'b0;
    memory_address      = '0;
    memory_write_data   = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (grant_s[k]) begin
        memory_write_enable = request_write[k];
        memory_read_enable  = !request_write[k];
        memory_address      = request_address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        memory_write_data   = request_write_data[k*WIDTH +: WIDTH];
      end else begin
        memory_write_enable = memory_write_enable;
      end
    end
  end

`ifdef SHARED_RAM_ARBITER_FIXED_PRIORITY_EN
  assign priority_pointer_s = '0;
`else
  logic [POINTER_WIDTH-1:0] priority_pointer_r;

  // Rotate the pointer past the client that was just served; hold it on idle cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      priority_pointer_r <= '0;
    end else if (found_s) begin
      priority_pointer_r <= next_pointer_s;
    end else begin
      priority_pointer_r <= priority_pointer_r;
    end
  end

  assign priority_pointer_s = priority_pointer_r;
`endif

  // Flag the reading client for the cycle its RAM data comes back.
  always_ff @(posedge clock) begin
    if (reset) begin
      response_valid_r <= '0;
    end else begin
      response_valid_r <= grant_s & ~request_write;
    end
  end

  assign response_valid = response_valid_r;
  assign response_data  = (|response_valid_r) ? memory_read_data : '0;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed vector bench for shared_ram_arbiter with a behavioural single-port RAM.
module tb_shared_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  request_valid, request_ready, request_write, response_valid;
  logic [7:0]  request_address;
  logic [15:0] request_write_data;
  logic [7:0]  response_data, memory_write_data, memory_read_data;
  logic        memory_write_enable, memory_read_enable;
  logic [3:0]  memory_address;

  logic [2:0]  valid3, ready3, response_valid3;
  logic [7:0]  response_data3, memory_write_data3;
  logic        memory_write_enable3, memory_read_enable3;
  logic [3:0]  memory_address3;

  logic [7:0]  mem [16];

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  shared_ram_arbiter #(.REQUESTERS(2), .WIDTH(8), .DEPTH(16)) u_dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready),
    .request_write(request_write), .request_address(request_address),
    .request_write_data(request_write_data),
    .response_valid(response_valid), .response_data(response_data),
    .memory_write_enable(memory_write_enable), .memory_read_enable(memory_read_enable),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data)
  );

  shared_ram_arbiter #(.REQUESTERS(3), .WIDTH(8), .DEPTH(16)) u_dut3 (
    .clock(clock), .reset(reset),
    .request_valid(valid3), .request_ready(ready3),
    .request_write(3'b000), .request_address(12'h000),
    .request_write_data(24'h000000),
    .response_valid(response_valid3), .response_data(response_data3),
    .memory_write_enable(memory_write_enable3), .memory_read_enable(memory_read_enable3),
    .memory_address(memory_address3), .memory_write_data(memory_write_data3),
    .memory_read_data(8'h00)
  );

  // Single-port RAM: write on the edge, registered read data.
  always @(posedge clock) begin
    if (memory_write_enable) mem[memory_address] <= memory_write_data;
    if (memory_read_enable) memory_read_data <= mem[memory_address];
  end

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  ready;
    logic        we;
    logic        re;
    logic [3:0]  maddr;
    logic [7:0]  mwdata;
    logic [1:0]  rvalid;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] v, input logic [1:0] w,
                     input logic [7:0] a, input logic [15:0] d, input logic [1:0] rdy,
                     input logic we, input logic re, input logic [3:0] ma,
                     input logic [7:0] md, input logic [1:0] rv, input logic [7:0] rd);
    vecs.push_back('{r, v, w, a, d, rdy, we, re, ma, md, rv, rd});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    request_valid = 2'b00;
    request_write = 2'b00;
    request_address = 8'h00;
    request_write_data = 16'h0000;
    valid3 = 3'b000;
    next_cycle();

    // reset held with both clients requesting
    for (int i = 0; i < 3; i++) add(1'b1, 2'b11, 2'b00, 8'h21, 16'h0000, 2'b00, 1'b0, 1'b0, 4'h0, 8'h00, 2'b00, 8'h00);
    add(1'b0, 2'b01, 2'b01, 8'h01, 16'h0011, 2'b01, 1'b1, 1'b0, 4'h1, 8'h11, 2'b00, 8'h00);
    add(1'b0, 2'b10, 2'b10, 8'h20, 16'h2200, 2'b10, 1'b1, 1'b0, 4'h2, 8'h22, 2'b00, 8'h00);
    add(1'b0, 2'b01, 2'b01, 8'h03, 16'h00A5, 2'b01, 1'b1, 1'b0, 4'h3, 8'hA5, 2'b00, 8'h00);
    add(1'b0, 2'b10, 2'b00, 8'h30, 16'h0000, 2'b10, 1'b0, 1'b1, 4'h3, 8'h00, 2'b00, 8'h00);
    add(1'b0, 2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 1'b0, 1'b0, 4'h0, 8'h00, 2'b10, 8'hA5);
`ifdef SHARED_RAM_ARBITER_FIXED_PRIORITY_EN
    add(1'b0, 2'b11, 2'b00, 8'h21, 16'h0000, 2'b01, 1'b0, 1'b1, 4'h1, 8'h00, 2'b00, 8'h00);
    add(1'b0, 2'b11, 2'b00, 8'h21, 16'h0000, 2'b01, 1'b0, 1'b1, 4'h1, 8'h00, 2'b01, 8'h11);
    add(1'b0, 2'b11, 2'b00, 8'h21, 16'h0000, 2'b01, 1'b0, 1'b1, 4'h1, 8'h00, 2'b01, 8'h11);
    add(1'b0, 2'b11, 2'b00, 8'h21, 16'h0000, 2'b01, 1'b0, 1'b1, 4'h1, 8'h00, 2'b01, 8'h11);
    add(1'b0, 2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 1'b0, 1'b0, 4'h0, 8'h00, 2'b01, 8'h11);
`else
    add(1'b0, 2'b11, 2'b00, 8'h21, 16'h0000, 2'b01, 1'b0, 1'b1, 4'h1, 8'h00, 2'b00, 8'h00);
    add(1'b0, 2'b11, 2'b00, 8'h21, 16'h0000, 2'b10, 1'b0, 1'b1, 4'h2, 8'h00, 2'b01, 8'h11);
    add(1'b0, 2'b11, 2'b00, 8'h21, 16'h0000, 2'b01, 1'b0, 1'b1, 4'h1, 8'h00, 2'b10, 8'h22);
    add(1'b0, 2'b11, 2'b00, 8'h21, 16'h0000, 2'b10, 1'b0, 1'b1, 4'h2, 8'h00, 2'b01, 8'h11);
    add(1'b0, 2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 1'b0, 1'b0, 4'h0, 8'h00, 2'b10, 8'h22);
`endif

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      request_valid = vecs[i].valid;
      request_write = vecs[i].write;
      request_address = vecs[i].addr;
      request_write_data = vecs[i].wdata;
      @(negedge clock);
      vectors++;
      check($sformatf("v%0d ready", i), 32'(request_ready), 32'(vecs[i].ready));
      check($sformatf("v%0d we", i), 32'(memory_write_enable), 32'(vecs[i].we));
      check($sformatf("v%0d re", i), 32'(memory_read_enable), 32'(vecs[i].re));
      check($sformatf("v%0d addr", i), 32'(memory_address), 32'(vecs[i].maddr));
      check($sformatf("v%0d wdata", i), 32'(memory_write_data), 32'(vecs[i].mwdata));
      check($sformatf("v%0d rvalid", i), 32'(response_valid), 32'(vecs[i].rvalid));
      check($sformatf("v%0d rdata", i), 32'(response_data), 32'(vecs[i].rdata));
      next_cycle();
    end

    // Read accepted just before reset: pulse survives into the first reset cycle only.
    request_valid = 2'b01; request_write = 2'b00; request_address = 8'h03;
    @(negedge clock); vectors++;
    check("midreset accept", 32'(request_ready), 32'(2'b01));
    next_cycle();
    reset = 1'b1; request_valid = 2'b11; request_address = 8'h21;
    @(negedge clock); vectors++;
    check("midreset ready", 32'(request_ready), 32'(2'b00));
    check("midreset re", 32'(memory_read_enable), 32'(1'b0));
    check("midreset pulse", 32'(response_valid), 32'(2'b01));
    check("midreset data", 32'(response_data), 32'(8'hA5));
    next_cycle();
    @(negedge clock); vectors++;
    check("midreset cleared", 32'(response_valid), 32'(2'b00));
    next_cycle();
    reset = 1'b0;
    @(negedge clock); vectors++;
    check("post reset grant", 32'(request_ready), 32'(2'b01));
    next_cycle();
    request_valid = 2'b00;

    // Three clients: move the pointer to 1, then contend between 0 and 2.
    valid3 = 3'b001;
    @(negedge clock); vectors++;
    check("r3 seed", 32'(ready3), 32'(3'b001));
    next_cycle();
    valid3 = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); vectors++;
`ifdef SHARED_RAM_ARBITER_FIXED_PRIORITY_EN
      check($sformatf("r3 wrap %0d", i), 32'(ready3), 32'(3'b001));
`else
      check($sformatf("r3 wrap %0d", i), 32'(ready3), (i == 1) ? 32'(3'b001) : 32'(3'b100));
`endif
      next_cycle();
    end
    valid3 = 3'b000;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
